// File: rtl/decode_stage_buf.sv
// decode_stage_buf: registered RV32I decode stage with a DEPTH-entry FIFO.
// Fetched instructions are decoded combinationally at the input and stored
// already decoded, so execute sees registered control with no in->out path.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    alu_ops         aluop;
    branch_funct3_t cmpop;
    logic           load_regfile;
    logic [1:0]     pc_mux_sel;
    logic           alumux1_sel;
    logic [2:0]     alumux2_sel;
    logic [2:0]     regfilemux_sel;
    logic           cmpmux_sel;
    logic [2:0]     byte_mux_sel;
    logic [2:0]     half_mux_sel;
  } rv32i_control_word;

endpackage

module decode_stage_buf
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              ir_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output rv32i_control_word        ctrl_o,
  output logic [4:0]               rd_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [XLEN-1:0]          imm_o,
  output logic [XLEN-1:0]          pc_o,
  output logic                     illegal_o,
  output logic                     muldiv_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              illegal;
    logic              muldiv;
  } entry_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  rv32i_control_word dec_ctrl;
  logic              dec_illegal;
  logic              dec_muldiv;
  logic [31:0]       imm32;
  entry_t            dec_entry;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   count;
  logic              do_enq;
  logic              do_deq;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];

  // Decode the incoming instruction into control, immediate and illegal flag.
  // Anything found illegal collapses to an all-zero control word and immediate.
  always_comb begin
    dec_ctrl       = '0;
    dec_ctrl.aluop = alu_ops'(funct3);
    dec_ctrl.cmpop = branch_funct3_t'(funct3);
    dec_illegal    = 1'b0;
    dec_muldiv     = 1'b0;
    imm32          = '0;
    case (opcode)
      op_lui: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.regfilemux_sel = 3'd2;
        imm32 = {ir_i[31:12], 12'h000};
      end
      op_auipc: begin
        dec_ctrl.load_regfile = 1'b1;
        dec_ctrl.alumux1_sel  = 1'b1;
        dec_ctrl.alumux2_sel  = 3'd1;
        imm32 = {ir_i[31:12], 12'h000};
      end
      op_jal: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.pc_mux_sel     = 2'd1;
        dec_ctrl.alumux1_sel    = 1'b1;
        dec_ctrl.alumux2_sel    = 3'd4;
        dec_ctrl.aluop          = alu_add;
        dec_ctrl.regfilemux_sel = 3'd4;
        imm32 = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      end
      op_jalr: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.aluop          = alu_add;
        dec_ctrl.regfilemux_sel = 3'd4;
        dec_ctrl.pc_mux_sel     = 2'd1;
        imm32 = {{21{ir_i[31]}}, ir_i[30:20]};
      end
      op_load: begin
        dec_ctrl.aluop        = alu_add;
        dec_ctrl.load_regfile = 1'b1;
        imm32 = {{21{ir_i[31]}}, ir_i[30:20]};
        case (funct3)
          3'b000: begin
            dec_ctrl.regfilemux_sel = 3'd5;
            dec_ctrl.byte_mux_sel   = 3'd4;
          end
          3'b001: begin
            dec_ctrl.regfilemux_sel = 3'd6;
            dec_ctrl.half_mux_sel   = 3'd4;
          end
          3'b010: dec_ctrl.regfilemux_sel = 3'd3;
          3'b100: dec_ctrl.regfilemux_sel = 3'd5;
          3'b101: dec_ctrl.regfilemux_sel = 3'd6;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_store: begin
        dec_ctrl.alumux2_sel = 3'd3;
        dec_ctrl.aluop       = alu_add;
        imm32 = {{21{ir_i[31]}}, ir_i[30:25], ir_i[11:7]};
        if (funct3 > 3'b010) dec_illegal = 1'b1;
      end
      op_imm: begin
        dec_ctrl.load_regfile = 1'b1;
        imm32 = {{21{ir_i[31]}}, ir_i[30:20]};
        if (funct3 == 3'b010) begin
          dec_ctrl.cmpop          = blt;
          dec_ctrl.regfilemux_sel = 3'd1;
          dec_ctrl.cmpmux_sel     = 1'b1;
        end else if (funct3 == 3'b011) begin
          dec_ctrl.cmpop          = bltu;
          dec_ctrl.regfilemux_sel = 3'd1;
          dec_ctrl.cmpmux_sel     = 1'b1;
        end else if (funct3 == 3'b101 && funct7[5]) begin
          dec_ctrl.aluop = alu_sra;
        end
      end
      op_reg: begin
        dec_ctrl.load_regfile = 1'b1;
        case (funct7)
          7'b0000000, 7'b0100000: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
              dec_ctrl.regfilemux_sel = 3'd1;
            end else begin
              dec_ctrl.alumux2_sel = 3'd5;
              if (funct3 == 3'b000 && funct7[5]) dec_ctrl.aluop = alu_sub;
              if (funct3 == 3'b101 && funct7[5]) dec_ctrl.aluop = alu_sra;
            end
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: begin
            dec_muldiv              = 1'b1;
            dec_ctrl.regfilemux_sel = 3'd0;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      op_br: begin
        dec_ctrl.pc_mux_sel  = 2'd2;
        dec_ctrl.alumux1_sel = 1'b1;
        dec_ctrl.alumux2_sel = 3'd2;
        dec_ctrl.aluop       = alu_add;
        imm32 = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl   = '0;
      imm32      = '0;
      dec_muldiv = 1'b0;
    end
  end

  // Pack the decoded fields into one FIFO entry, sign-extending the immediate.
  always_comb begin
    dec_entry         = '0;
    dec_entry.ctrl    = dec_ctrl;
    dec_entry.rd      = ir_i[11:7];
    dec_entry.rs1     = ir_i[19:15];
    dec_entry.rs2     = ir_i[24:20];
    dec_entry.imm     = XLEN'($signed(imm32));
    dec_entry.pc      = pc_i;
    dec_entry.illegal = dec_illegal;
    dec_entry.muldiv  = dec_muldiv;
  end

  // Flush wins over both handshakes so a redirect never leaks an old entry.
  assign in_ready  = (count < CNTW'(DEPTH));
  assign out_valid = (count != '0);
  assign do_enq    = in_valid && in_ready && !flush;
  assign do_deq    = out_valid && out_ready && !flush;

  // Occupancy and pointer bookkeeping; reset and flush both empty the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= dec_entry;
  end

  // Head entry is forced to zero whenever the buffer is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign ctrl_o    = head.ctrl;
  assign rd_o      = head.rd;
  assign rs1_o     = head.rs1;
  assign rs2_o     = head.rs2;
  assign imm_o     = head.imm;
  assign pc_o      = head.pc;
  assign illegal_o = head.illegal;
  assign muldiv_o  = head.muldiv;
  assign count_o   = count;

endmodule

// File: tb/tb_decode_stage_buf.sv
// tb_decode_stage_buf: directed bench for decode_stage_buf with a scoreboard
// queue of expected head entries, popped whenever the bench consumes the head.
// Honours DECODE_RV32M_EN to pick the expected M-extension behaviour.

module tb_decode_stage_buf;
  import rv32i_types::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0]       ir;
    logic [31:0]       pc;
    rv32i_control_word ctrl;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              illegal;
    logic              muldiv;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            ir_i;
  logic [XLEN-1:0]        pc_i;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  rv32i_control_word      ctrl_o;
  logic [4:0]             rd_o;
  logic [4:0]             rs1_o;
  logic [4:0]             rs2_o;
  logic [XLEN-1:0]        imm_o;
  logic [XLEN-1:0]        pc_o;
  logic                   illegal_o;
  logic                   muldiv_o;
  logic [$clog2(DEPTH):0] count_o;

  exp_t sb[$];
  exp_t cur;
  int   n_compared;
  int   n_mismatched;

  decode_stage_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ir_i(ir_i), .pc_i(pc_i), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ctrl_o(ctrl_o), .rd_o(rd_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .imm_o(imm_o), .pc_o(pc_o), .illegal_o(illegal_o),
    .muldiv_o(muldiv_o), .count_o(count_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rv32i_control_word mk_ctrl(
    input logic [2:0] aluop, input logic [2:0] cmpop, input logic ldr,
    input logic [1:0] pcm, input logic am1, input logic [2:0] am2,
    input logic [2:0] rfm, input logic cmpm, input logic [2:0] bym,
    input logic [2:0] hfm);
    rv32i_control_word c;
    c.aluop          = alu_ops'(aluop);
    c.cmpop          = branch_funct3_t'(cmpop);
    c.load_regfile   = ldr;
    c.pc_mux_sel     = pcm;
    c.alumux1_sel    = am1;
    c.alumux2_sel    = am2;
    c.regfilemux_sel = rfm;
    c.cmpmux_sel     = cmpm;
    c.byte_mux_sel   = bym;
    c.half_mux_sel   = hfm;
    return c;
  endfunction

  function automatic exp_t mk(input logic [31:0] ir, input logic [31:0] pc,
    input rv32i_control_word c, input logic [4:0] rd, input logic [31:0] imm,
    input logic ill, input logic md);
    exp_t e;
    e.ir = ir; e.pc = pc; e.ctrl = c; e.rd = rd; e.imm = imm;
    e.illegal = ill; e.muldiv = md;
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input exp_t e, input logic v);
    cur      = e;
    in_valid = v;
    ir_i     = e.ir;
    pc_i     = e.pc;
  endtask

  task automatic check_empty_outputs(input string where);
    check_output({where, "_ctrl_zero"}, 64'(ctrl_o), 64'd0);
    check_output({where, "_imm_zero"}, 64'(imm_o), 64'd0);
    check_output({where, "_pc_zero"}, 64'(pc_o), 64'd0);
    check_output({where, "_rd_zero"}, 64'(rd_o), 64'd0);
    check_output({where, "_illegal_zero"}, 64'(illegal_o), 64'd0);
    check_output({where, "_muldiv_zero"}, 64'(muldiv_o), 64'd0);
  endtask

  // One cycle: check handshake/occupancy against the model, consume the
  // head if out_ready, record an accepted push, then advance to next negedge.
  task automatic tick();
    exp_t h;
    bit   was_full;
    #1;
    was_full = (sb.size() >= DEPTH);
    check_output("in_ready", 64'(in_ready), 64'(!was_full));
    check_output("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check_output("count", 64'(count_o), 64'(sb.size()));
    if (sb.size() == 0) check_empty_outputs("empty");
    if (flush) begin
      sb.delete();
    end else begin
      if (out_ready && sb.size() != 0) begin
        h = sb.pop_front();
        check_output($sformatf("ctrl_%08h", h.ir), 64'(ctrl_o), 64'(h.ctrl));
        check_output($sformatf("rd_%08h", h.ir), 64'(rd_o), 64'(h.rd));
        check_output($sformatf("rs1_%08h", h.ir), 64'(rs1_o), 64'(h.ir[19:15]));
        check_output($sformatf("rs2_%08h", h.ir), 64'(rs2_o), 64'(h.ir[24:20]));
        check_output($sformatf("imm_%08h", h.ir), 64'(imm_o), 64'(h.imm));
        check_output($sformatf("pc_%08h", h.ir), 64'(pc_o), 64'(h.pc));
        check_output($sformatf("illegal_%08h", h.ir), 64'(illegal_o), 64'(h.illegal));
        check_output($sformatf("muldiv_%08h", h.ir), 64'(muldiv_o), 64'(h.muldiv));
      end
      if (in_valid && !was_full) sb.push_back(cur);
    end
    @(negedge clk);
  endtask

  exp_t e_addi, e_sub, e_beq, e_lw, e_lui, e_sw, e_jal, e_srai, e_badld;
  exp_t e_flushed, e_jal2, e_mul, e_ones, e_x, e_y;

  // Directed sequence of all scenarios.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0; in_valid = 1'b0; ir_i = '0; pc_i = '0;
    flush = 1'b0; out_ready = 1'b0;

    e_addi  = mk(32'h00500093, 32'h100, mk_ctrl(3'd0,3'd0,1,0,0,3'd0,3'd0,0,0,0), 5'd1, 32'd5, 0, 0);
    e_sub   = mk(32'h402081B3, 32'h104, mk_ctrl(3'd3,3'd0,1,0,0,3'd5,3'd0,0,0,0), 5'd3, 32'd0, 0, 0);
    e_beq   = mk(32'hFE000EE3, 32'h108, mk_ctrl(3'd0,3'd0,0,2,1,3'd2,3'd0,0,0,0), 5'd29, 32'hFFFFFFFC, 0, 0);
    e_lw    = mk(32'h0080A103, 32'h200, mk_ctrl(3'd0,3'd2,1,0,0,3'd0,3'd3,0,0,0), 5'd2, 32'd8, 0, 0);
    e_lui   = mk(32'h12345237, 32'h204, mk_ctrl(3'd5,3'd5,1,0,0,3'd0,3'd2,0,0,0), 5'd4, 32'h12345000, 0, 0);
    e_sw    = mk(32'h0020A223, 32'h208, mk_ctrl(3'd0,3'd2,0,0,0,3'd3,3'd0,0,0,0), 5'd4, 32'd4, 0, 0);
    e_jal   = mk(32'h010000EF, 32'h20C, mk_ctrl(3'd0,3'd0,1,1,1,3'd4,3'd4,0,0,0), 5'd1, 32'd16, 0, 0);
    e_srai  = mk(32'h4030D093, 32'h300, mk_ctrl(3'd2,3'd5,1,0,0,3'd0,3'd0,0,0,0), 5'd1, 32'd1027, 0, 0);
    e_badld = mk(32'h0000B003, 32'h304, '0, 5'd0, 32'd0, 1, 0);
    e_flushed = mk(32'h00500093, 32'h308, mk_ctrl(3'd0,3'd0,1,0,0,3'd0,3'd0,0,0,0), 5'd1, 32'd5, 0, 0);
    e_jal2  = mk(32'h010000EF, 32'h400, mk_ctrl(3'd0,3'd0,1,1,1,3'd4,3'd4,0,0,0), 5'd1, 32'd16, 0, 0);
`ifdef DECODE_RV32M_EN
    e_mul   = mk(32'h027302B3, 32'h500, mk_ctrl(3'd0,3'd0,1,0,0,3'd0,3'd0,0,0,0), 5'd5, 32'd0, 0, 1);
`else
    e_mul   = mk(32'h027302B3, 32'h500, '0, 5'd5, 32'd0, 1, 0);
`endif
    e_ones  = mk(32'hFFFFFFFF, 32'h504, '0, 5'd31, 32'd0, 1, 0);
    e_x     = mk(32'h0080A103, 32'h600, mk_ctrl(3'd0,3'd2,1,0,0,3'd0,3'd3,0,0,0), 5'd2, 32'd8, 0, 0);
    e_y     = mk(32'h12345237, 32'h604, mk_ctrl(3'd5,3'd5,1,0,0,3'd0,3'd2,0,0,0), 5'd4, 32'h12345000, 0, 0);

    // Reset state while held in reset.
    #3;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_count", 64'(count_o), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_empty_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single addi: visible one edge after the accept.
    $display("[TB] single addi");
    out_ready = 1'b1;
    apply_stimulus(e_addi, 1'b1);
    tick();
    apply_stimulus(e_addi, 1'b0);
    tick();
    tick();

    // Back-to-back sub then beq.
    $display("[TB] sub then beq");
    apply_stimulus(e_sub, 1'b1);
    tick();
    apply_stimulus(e_beq, 1'b1);
    tick();
    apply_stimulus(e_beq, 1'b0);
    tick();
    tick();

    // Fill to DEPTH with out_ready low, then drain with simultaneous push/pop.
    $display("[TB] full buffer and wrap");
    out_ready = 1'b0;
    apply_stimulus(e_lw, 1'b1);
    tick();
    apply_stimulus(e_lui, 1'b1);
    tick();
    apply_stimulus(e_sw, 1'b1);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    apply_stimulus(e_jal, 1'b1);
    tick();
    apply_stimulus(e_jal, 1'b0);
    tick();
    tick();

    // Flush together with in_valid: flushed instruction must never appear.
    $display("[TB] flush");
    out_ready = 1'b0;
    apply_stimulus(e_srai, 1'b1);
    tick();
    apply_stimulus(e_badld, 1'b1);
    tick();
    apply_stimulus(e_flushed, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(e_jal2, 1'b1);
    tick();
    apply_stimulus(e_jal2, 1'b0);
    tick();
    tick();

    // M-extension encoding and an all-ones illegal word.
    $display("[TB] mul and illegal");
    apply_stimulus(e_mul, 1'b1);
    tick();
    apply_stimulus(e_ones, 1'b1);
    tick();
    apply_stimulus(e_ones, 1'b0);
    tick();
    tick();

    // Asynchronous reset mid-cycle with two entries buffered.
    $display("[TB] async reset");
    out_ready = 1'b0;
    apply_stimulus(e_x, 1'b1);
    tick();
    apply_stimulus(e_y, 1'b1);
    tick();
    apply_stimulus(e_y, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", 64'(out_valid), 64'd0);
    check_output("arst_count", 64'(count_o), 64'd0);
    check_output("arst_in_ready", 64'(in_ready), 64'd1);
    check_empty_outputs("arst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
